stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM between the two debounce outputs (start/stop, lap/reset) and the time-count datapath.
//  Turns debounced button levels into run enable, clear pulse and lap display-hold.
//  Classifies lap/reset presses as short (acted on release) or long (acted at threshold).
// PARAMETERS
//  CLK_FREQ_KHZ   100_000  clk cycles per 1 ms tick (same meaning as debounce)
//  LONG_PRESS_MS  1000     hold time in ms at which lap/reset becomes a long press
//  HOLD_W         16       width of ms hold counter; must satisfy 2**HOLD_W > LONG_PRESS_MS
// PORTS
//  clk        in   1  system clock; single clock domain
//  rst_n      in   1  reset, synchronous, active-low
//  btn_ss     in   1  debounced start/stop level, 1 = pressed
//  btn_lr     in   1  debounced lap/reset level, 1 = pressed
//  run        out  1  count enable to time datapath
//  clr        out  1  one-cycle pulse: zero the time counters
//  lap_hold   out  1  freeze display at current value; counting continues underneath
//  state      out  2  FSM state for debug/LEDs: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, run=0, clr=0, lap_hold=0, prescaler=0, hold cnt=0, long_fired=0.
//  - During reset, edge regs load current btn levels: button held through reset gives no event.
//  - Press = rising edge (btn=1, prev=0); release = falling edge. All outputs registered;
//    they change on the posedge that first samples the new btn level (1-cycle latency).
//  - ms prescaler counts 0..CLK_FREQ_KHZ-1 free-running; tick on wrap.
//  - Hold cnt: cleared on btn_lr press; +1 per tick while btn_lr=1; saturates at LONG_PRESS_MS.
//  - Long press: hold cnt reaches LONG_PRESS_MS with btn_lr=1 and long_fired=0
//    -> clr pulse, state=IDLE, long_fired=1. Fires once per press; that press's release is ignored.
//    long_fired clears on next btn_lr press.
//  - Short press: btn_lr release with long_fired=0.
//  - Transitions (run = state in {RUN,LAP}; lap_hold = state==LAP):
//    IDLE : ss press -> RUN.      short lr -> IDLE, no clr.
//    RUN  : ss press -> PAUSE.    short lr -> LAP.
//    LAP  : ss press -> PAUSE.    short lr -> RUN (release hold).
//    PAUSE: ss press -> RUN.      short lr -> IDLE with clr pulse.
//  - Simultaneous events, priority: long press > ss press > short lr. Lower-priority event is dropped, not queued.
//  - clr is exactly one cycle; it never coincides with run=1 (target state is IDLE).
//  - Reset mid-press: hold cnt and long_fired clear; the held button needs a fresh press to act.
//  - Both buttons held: each is classified independently; priority rule applies per cycle.
// STRUCTURE
//  - stopwatch_defs.vh (shared include): state encodings ST_IDLE..ST_LAP. The time datapath and display mux use them too.
//  - Sub-module btn_press_timer: ms prescaler, hold counter, long_fired flag.
//    Outputs: short_evt and long_evt, single-cycle.
//  - Top: edge detect for btn_ss, FSM, registered outputs.
// TESTING  (bench uses CLK_FREQ_KHZ=10, LONG_PRESS_MS=5 -> long = 50 cycles)
//  1 reset with btn_ss=1 held, release rst_n -> state stays 0, run=0, no clr.
//  2 ss press, release, press -> run 0->1 on first sampled edge, state 1 then 2, run=0.
//  3 RUN, lr held 20 cycles then released -> lap_hold=1, run=1, state=3. Repeat lr short -> state=1, lap_hold=0.
//  4 PAUSE, lr held 60 cycles -> clr high exactly 1 cycle near cycle 50, state=0. Release -> no further clr.
//  5 PAUSE, ss press on same cycle as lr release -> state=1, no clr; lr event dropped.
//  6 RUN, lr held 30 cycles, rst_n pulsed low 1 cycle, lr held 40 more then released -> state=0, no clr, no lap.

Source files
------------

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control path: state encodings used by
// the controller, the time datapath and the display mux.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  // The time counters advance in RUN and also underneath a lap hold.
  function automatic logic state_runs(state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-level inputs and control outputs between the debounce stage,
// the stopwatch controller and the time datapath.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic   btn_ss;    // debounced start/stop level, 1 = pressed
  logic   btn_lr;    // debounced lap/reset level, 1 = pressed
  logic   run;       // count enable
  logic   clr;       // one-cycle clear pulse
  logic   lap_hold;  // freeze display, counting continues
  state_t state;     // debug / LED view of the FSM

  // Button side (debounce outputs, time datapath consumes the results).
  modport master (
    output btn_ss, btn_lr,
    input  run, clr, lap_hold, state
  );

  // Controller side.
  modport slave (
    input  btn_ss, btn_lr,
    output run, clr, lap_hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl_btn_press_timer.sv
// Lap/reset press classifier: a free-running ms prescaler, a saturating hold
// counter and a long-press latch. Emits a single-cycle short event on release
// and a single-cycle long event when the hold threshold is reached.
module stopwatch_ctrl_btn_press_timer #(
  parameter int CLK_FREQ_KHZ  = 100_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int HOLD_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_short_evt,
  output logic o_long_evt
);

  localparam int PRESC_W = (CLK_FREQ_KHZ > 1) ? $clog2(CLK_FREQ_KHZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ_KHZ - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LONG  = HOLD_W'(LONG_PRESS_MS);

  logic [PRESC_W-1:0] r_presc;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_prev;
  logic               r_long_fired;
  logic               r_armed;
  logic               w_tick;
  logic               w_press;
  logic               w_release;

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_press   = i_btn & ~r_prev;
  assign w_release = ~i_btn & r_prev;

  // A button held through reset never saw a press, so it stays disarmed and
  // can neither long-fire nor produce a release event until pressed afresh.
  assign o_long_evt  = r_armed & i_btn & r_prev & ~r_long_fired & (r_hold == HOLD_LONG);
  assign o_short_evt = r_armed & w_release & ~r_long_fired;

  // Edge register; loads the live level during reset so a held button is not a press.
  always_ff @(posedge clk) begin
    r_prev <= i_btn;
  end

  // Free-running 1 ms prescaler.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Hold time in ms since the last press, saturating at the long threshold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_press) begin
      r_hold <= '0;
    end else if (i_btn && w_tick && (r_hold != HOLD_LONG)) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Long-fired latch (suppresses the release of that press) and arm flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_long_fired <= 1'b0;
      r_armed      <= 1'b0;
    end else begin
      if (w_press) begin
        r_long_fired <= 1'b0;
        r_armed      <= 1'b1;
      end else if (o_long_evt) begin
        r_long_fired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns debounced start/stop and lap/reset levels into
// run enable, a one-cycle clear pulse and a lap display hold.
module stopwatch_ctrl #(
  parameter int CLK_FREQ_KHZ  = 100_000,
  parameter int LONG_PRESS_MS = 1000,
  parameter int HOLD_W        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  stopwatch_ctrl_if.slave bus
);
  import stopwatch_ctrl_pkg::*;

  state_t r_state;
  state_t w_state_next;
  logic   w_clr_next;
  logic   r_run;
  logic   r_clr;
  logic   r_lap_hold;
  logic   r_ss_prev;
  logic   w_ss_press;
  logic   w_short_evt;
  logic   w_long_evt;

  stopwatch_ctrl_btn_press_timer #(
    .CLK_FREQ_KHZ (CLK_FREQ_KHZ),
    .LONG_PRESS_MS(LONG_PRESS_MS),
    .HOLD_W       (HOLD_W)
  ) u_lr_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn      (bus.btn_lr),
    .o_short_evt(w_short_evt),
    .o_long_evt (w_long_evt)
  );

  assign w_ss_press = bus.btn_ss & ~r_ss_prev;

  // Start/stop edge register; tracks the level during reset too.
  always_ff @(posedge clk) begin
    r_ss_prev <= bus.btn_ss;
  end

  // State and registered outputs, all updated from the next-state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_run      <= 1'b0;
      r_clr      <= 1'b0;
      r_lap_hold <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_run      <= state_runs(w_state_next);
      r_clr      <= w_clr_next;
      r_lap_hold <= (w_state_next == ST_LAP);
    end
  end

  // Next state: long press beats start/stop, which beats a short lap/reset;
  // the losing event in a cycle is simply dropped.
  always_comb begin
    w_state_next = r_state;
    w_clr_next   = 1'b0;
    if (w_long_evt) begin
      w_state_next = ST_IDLE;
      w_clr_next   = 1'b1;
    end else if (w_ss_press) begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_PAUSE;
        ST_LAP:   w_state_next = ST_PAUSE;
        ST_PAUSE: w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end else if (w_short_evt) begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_IDLE;
        ST_RUN:   w_state_next = ST_LAP;
        ST_LAP:   w_state_next = ST_RUN;
        ST_PAUSE: begin
          w_state_next = ST_IDLE;
          w_clr_next   = 1'b1;
        end
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  assign bus.run      = r_run;
  assign bus.clr      = r_clr;
  assign bus.lap_hold = r_lap_hold;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 10-cycle ms tick and a 5 ms long
// press, so a long press fires roughly 50 cycles after the press is sampled.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   clr_cnt;
  int   clr_cyc;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .CLK_FREQ_KHZ (10),
    .LONG_PRESS_MS(5),
    .HOLD_W       (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Count every clr pulse and remember when the last one was seen.
  initial begin
    clr_cnt = 0;
    clr_cyc = 0;
  end
  always @(negedge clk) begin
    if (bus.clr === 1'b1) begin
      clr_cnt = clr_cnt + 1;
      clr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges, ending 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss_tap();
    bus.btn_ss = 1'b1;
    tick(1);
    bus.btn_ss = 1'b0;
    tick(2);
  endtask

  task automatic lr_tap(input int hold);
    bus.btn_lr = 1'b1;
    tick(hold);
    bus.btn_lr = 1'b0;
    tick(1);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int k;
    n_checks = 0;
    n_pass   = 0;
    bus.btn_ss = 1'b0;
    bus.btn_lr = 1'b0;

    // 1: reset with start/stop held, then release reset
    rst_n = 1'b0;
    bus.btn_ss = 1'b1;
    tick(3);
    check("rst_state", bus.state, 0);
    check("rst_run", bus.run, 0);
    check("rst_clr", bus.clr, 0);
    check("rst_lap", bus.lap_hold, 0);
    c0 = clr_cnt;
    rst_n = 1'b1;
    tick(3);
    check("t1_state", bus.state, 0);
    check("t1_run", bus.run, 0);
    bus.btn_ss = 1'b0;
    tick(2);
    check("t1_state_rel", bus.state, 0);
    check("t1_no_clr", clr_cnt - c0, 0);

    // 2: press, release, press with one-cycle latency
    bus.btn_ss = 1'b1;
    check("t2_run_pre", bus.run, 0);
    tick(1);
    check("t2_run", bus.run, 1);
    check("t2_state_run", bus.state, 1);
    bus.btn_ss = 1'b0;
    tick(2);
    bus.btn_ss = 1'b1;
    tick(1);
    check("t2_state_pause", bus.state, 2);
    check("t2_run_off", bus.run, 0);
    bus.btn_ss = 1'b0;
    tick(2);

    // 3: short lap from RUN, then short lap back to RUN
    ss_tap();
    check("t3_state_run", bus.state, 1);
    c0 = clr_cnt;
    bus.btn_lr = 1'b1;
    tick(20);
    check("t3_held_state", bus.state, 1);
    bus.btn_lr = 1'b0;
    tick(1);
    check("t3_state_lap", bus.state, 3);
    check("t3_run_lap", bus.run, 1);
    check("t3_lap_hold", bus.lap_hold, 1);
    tick(2);
    lr_tap(5);
    check("t3_state_back", bus.state, 1);
    check("t3_lap_off", bus.lap_hold, 0);
    check("t3_run_back", bus.run, 1);
    check("t3_no_clr", clr_cnt - c0, 0);

    // 4: long press from PAUSE
    ss_tap();
    check("t4_state_pause", bus.state, 2);
    c0 = clr_cnt;
    k  = cyc;
    bus.btn_lr = 1'b1;
    tick(60);
    check("t4_one_clr", clr_cnt - c0, 1);
    check("t4_clr_time", ((clr_cyc - k) >= 40 && (clr_cyc - k) <= 55) ? 1 : 0, 1);
    check("t4_state_idle", bus.state, 0);
    check("t4_run_off", bus.run, 0);
    bus.btn_lr = 1'b0;
    tick(5);
    check("t4_rel_no_clr", clr_cnt - c0, 1);
    check("t4_rel_state", bus.state, 0);

    // 5: start/stop press on the cycle lap/reset is released, in PAUSE
    ss_tap();
    ss_tap();
    check("t5_state_pause", bus.state, 2);
    c0 = clr_cnt;
    bus.btn_lr = 1'b1;
    tick(10);
    bus.btn_lr = 1'b0;
    bus.btn_ss = 1'b1;
    tick(1);
    check("t5_state_run", bus.state, 1);
    check("t5_run", bus.run, 1);
    bus.btn_ss = 1'b0;
    tick(3);
    check("t5_state_hold", bus.state, 1);
    check("t5_lap_off", bus.lap_hold, 0);
    check("t5_no_clr", clr_cnt - c0, 0);

    // Short lap/reset in PAUSE clears; in IDLE it does nothing
    ss_tap();
    check("sp_state_pause", bus.state, 2);
    bus.btn_lr = 1'b1;
    tick(3);
    bus.btn_lr = 1'b0;
    tick(1);
    check("sp_state_idle", bus.state, 0);
    check("sp_clr_on", bus.clr, 1);
    tick(1);
    check("sp_clr_off", bus.clr, 0);
    c0 = clr_cnt;
    lr_tap(3);
    check("si_state_idle", bus.state, 0);
    tick(2);
    check("si_no_clr", clr_cnt - c0, 0);

    // 6: reset in the middle of a lap/reset hold while running
    ss_tap();
    check("t6_state_run", bus.state, 1);
    c0 = clr_cnt;
    bus.btn_lr = 1'b1;
    tick(30);
    check("t6_held_state", bus.state, 1);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_state", bus.state, 0);
    check("t6_rst_run", bus.run, 0);
    rst_n = 1'b1;
    tick(40);
    check("t6_held2_state", bus.state, 0);
    bus.btn_lr = 1'b0;
    tick(2);
    check("t6_final_state", bus.state, 0);
    check("t6_no_lap", bus.lap_hold, 0);
    check("t6_no_clr", clr_cnt - c0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
